bf_result_drain: RTL and testbench
==================================

Name: bf_result_drain

Overview:
- Downstream stage of the Bellman-Ford core. It starts when the controller reaches its finish state.
- Reads the output SRAM from address 0 up to the final write address, inclusive.
- Streams each distance word out on a valid/ready interface.
- Final write address == 0 is the core's negative-cycle indication; it is reported as a flag instead of streaming data.

Parameters:
ADDR_W, 14, output SRAM address width
DATA_W, 16, distance word width
INF_VAL, 16'hFFFF, encoding of an unreachable (infinite) distance

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-low reset
done_in  in  1  one-cycle pulse from the controller on entering its finish state
last_addr  in  ADDR_W  final output-SRAM write address from the datapath; sampled with done_in
sram_re  out  1  output-SRAM read enable
sram_addr  out  ADDR_W  output-SRAM read address
sram_rdata  in  DATA_W  read data, valid exactly 1 cycle after sram_re
out_valid  out  1  stream beat valid
out_ready  in  1  downstream ready
out_data  out  DATA_W  distance word
out_inf  out  1  out_data == INF_VAL
out_last  out  1  final beat of the stream
neg_cycle  out  1  negative cycle detected; sticky until next accepted done_in or reset
busy  out  1  drain in progress
drain_done  out  1  one-cycle completion pulse

Behaviour:
- Reset (reset==0 sampled on clock): state IDLE, all outputs 0, buffer emptied, counters cleared. This applies mid-operation too: a stream in progress is aborted without out_last or drain_done.
- FSM states: IDLE, NEG, READ, FLUSH, FIN.
- IDLE:
  - done_in==1 latches last_addr and clears neg_cycle.
  - last_addr==0 goes to NEG; otherwise goes to READ with rd_ptr=0 and beats_left=last_addr+1.
  - beats_left is ADDR_W+1 bits wide, so last_addr=2^ADDR_W-1 does not wrap.
- NEG (1 cycle): neg_cycle<=1, then FIN. No out_valid is produced.
- READ:
  - Issue sram_re with sram_addr=rd_ptr only when (buffer occupancy + reads in flight) < 2; then rd_ptr++.
  - After the read of address last_addr is issued, go to FLUSH.
- FLUSH: wait until every buffered beat has been accepted, then go to FIN.
- FIN (1 cycle): drain_done=1, busy=0, then IDLE.
- busy is 1 in every state except IDLE, and is also 0 during the FIN cycle.
- Read data is written into a 2-entry buffer on the cycle after sram_re. out_* are driven from the head entry.
- Latency: with out_ready held high, done_in sampled at cycle 0 gives sram_re at cycle 1 and first out_valid at cycle 3. Steady state is 1 beat/cycle.
- Handshake:
  - A beat transfers when out_valid && out_ready.
  - While out_valid && !out_ready, out_data, out_inf and out_last hold stable.
  - out_valid never drops without a transfer.
- out_last=1 only on the beat for address last_addr (subject to Optional Feature).
- drain_done asserts the cycle after the last beat transfers.
- done_in outside IDLE is ignored.
- Words are passed unmodified; no arithmetic on data.

Optional Feature:
- Macro: BF_DRAIN_CHECKSUM_EN.
- Defined:
  - A DATA_W-bit wrapping sum of all transferred data beats is accumulated.
  - After the last data beat, one extra beat is emitted: out_data=checksum, out_inf=0, out_last=1.
  - The last data beat then has out_last=0.
  - The checksum is not emitted on the NEG path.
- Undefined: no accumulator, no extra beat.
- Ports are identical in both cases.

Decomposition:
- Package bf_pkg: ADDR_W, DATA_W, INF_VAL, and the drain FSM state enum. It is shared with the controller and datapath.
- Sub-module bf_skid_fifo: 2-entry valid/ready buffer with an occupancy output.

Test Plan:
- last_addr=3, SRAM[0..3]={0x0000,0x0005,0xFFFF,0x000C}, out_ready=1: 4 beats on consecutive cycles, first at done_in+3. out_inf=1 only on beat 2, out_last on beat 3. drain_done on the next cycle; neg_cycle=0.
- last_addr=0: neg_cycle=1 two cycles after done_in. out_valid stays 0. One drain_done pulse; neg_cycle holds until the next done_in.
- Same data, out_ready pattern 1,0,0,1,0,1,1: exactly 4 beats in order, no duplicates, out_data stable during stalls, no read issued while the buffer is full.
- reset=0 after 2 beats transferred: all outputs 0 on the next cycle. A new done_in with last_addr=1 streams 2 beats correctly.
- done_in re-pulsed during READ with last_addr=9: ignored, stream completes with 4 beats.
- With BF_DRAIN_CHECKSUM_EN, first test's data: 5 beats. The 5th has out_data=0x0010 and out_last=1; beat 3 has out_last=0.

Source files
------------

// File: rtl/bf_pkg.sv
// Shared Bellman-Ford core package: address/data widths, the infinite-distance
// encoding and the result-drain FSM state encoding. Used by the controller,
// the datapath and the result drain.
package bf_pkg;

    localparam int ADDR_W = 14;
    localparam int DATA_W = 16;
    localparam logic [DATA_W-1:0] INF_VAL = 16'hFFFF;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_NEG   = 3'd1,
        S_READ  = 3'd2,
        S_FLUSH = 3'd3,
        S_FIN   = 3'd4
    } drain_state_e;

endpackage

// File: rtl/bf_skid_fifo.sv
// Two-entry valid/ready buffer.
// Ports:
//   clock, reset      rising-edge clock, synchronous active-low reset
//   push, push_data   write one entry (caller guarantees room)
//   pop               remove the head entry (caller guarantees head_valid)
//   head_valid        buffer holds at least one entry
//   head_data         oldest entry
//   occupancy         number of held entries, 0..2
module bf_skid_fifo #(
    parameter int WIDTH = 18
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             head_valid,
    output logic [WIDTH-1:0] head_data,
    output logic [1:0]       occupancy
);

    logic [WIDTH-1:0] mem_q [2];
    logic             wr_idx;
    logic             rd_idx;
    logic [1:0]       cnt;

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_idx <= 1'b0;
            rd_idx <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (push) wr_idx <= ~wr_idx;
            if (pop)  rd_idx <= ~rd_idx;
            cnt <= cnt + 2'(push) - 2'(pop);
        end
    end

    // Storage carries no reset; cnt alone decides what is valid.
    always_ff @(posedge clock) begin
        if (push) mem_q[wr_idx] <= push_data;
    end

    assign head_valid = (cnt != 2'd0);
    assign head_data  = mem_q[rd_idx];
    assign occupancy  = cnt;

endmodule

// File: rtl/bf_result_drain.sv
// Result drain for the Bellman-Ford core. On done_in it reads the output SRAM
// from address 0 through last_addr and streams each distance word on a
// valid/ready port. last_addr == 0 signals a negative cycle: neg_cycle is set
// and no data is streamed.
// Optional macro BF_DRAIN_CHECKSUM_EN appends one beat holding the wrapping
// DATA_W-bit sum of all streamed words (that beat carries out_last).
// Ports:
//   clock, reset                 rising-edge clock, synchronous active-low reset
//   done_in, last_addr           start pulse and final SRAM address
//   sram_re, sram_addr           SRAM read request
//   sram_rdata                   SRAM data, one cycle after sram_re
//   out_valid/ready/data         result stream
//   out_inf, out_last            word is INF_VAL / final beat
//   neg_cycle                    sticky negative-cycle flag
//   busy, drain_done             activity and one-cycle completion pulse
module bf_result_drain #(
    parameter int                ADDR_W  = bf_pkg::ADDR_W,
    parameter int                DATA_W  = bf_pkg::DATA_W,
    parameter logic [DATA_W-1:0] INF_VAL = bf_pkg::INF_VAL
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              done_in,
    input  logic [ADDR_W-1:0] last_addr,
    output logic              sram_re,
    output logic [ADDR_W-1:0] sram_addr,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_inf,
    output logic              out_last,
    output logic              neg_cycle,
    output logic              busy,
    output logic              drain_done
);
    import bf_pkg::*;

    // Buffer payload: {is_checksum, last, data}
    localparam int PW = DATA_W + 2;

    drain_state_e      state, state_nxt;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   beats_left;
    logic              neg_q;
    logic              issue;
    logic              csum_push;
    logic              rd_vld_p0;
    logic              rd_last_p0;
    logic              push;
    logic [PW-1:0]     push_data;
    logic              pop;
    logic              head_valid;
    logic [PW-1:0]     head_data;
    logic [1:0]        occ;
    logic [2:0]        room_used;
    logic              read_ok;
    logic              empty_after;
    logic              last_rd;

    assign pop       = head_valid && out_ready;
    // Slots already claimed once this cycle's pop is accounted for; counting
    // the pop is what lets reads keep pace at one beat per cycle.
    assign room_used = 3'(occ) + 3'(rd_vld_p0) - 3'(pop);
    assign read_ok   = (room_used < 3'd2);
    // Nothing left in the buffer or in flight after this cycle.
    assign empty_after = !rd_vld_p0 && ((occ == 2'd0) || (occ == 2'd1 && pop));
    assign last_rd     = (beats_left == (ADDR_W+1)'(1));

`ifdef BF_DRAIN_CHECKSUM_EN
    logic              csum_sent;
    logic [DATA_W-1:0] csum_q;
    logic [DATA_W-1:0] csum_nxt;

    assign csum_nxt = csum_q + (pop ? head_data[DATA_W-1:0] : '0);

    always_ff @(posedge clock) begin
        if (!reset) begin
            csum_sent <= 1'b0;
        end else if (state == S_IDLE && done_in) begin
            csum_sent <= 1'b0;
        end else if (csum_push) begin
            csum_sent <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (state == S_IDLE && done_in) begin
            csum_q <= '0;
        end else if (pop && !csum_sent) begin
            csum_q <= csum_nxt;
        end
    end

    assign push_data = csum_push ? {1'b1, 1'b1, csum_nxt}
                                 : {1'b0, 1'b0, sram_rdata};
`else
    assign push_data = {1'b0, rd_last_p0, sram_rdata};
`endif

    assign push = rd_vld_p0 || csum_push;

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        csum_push = 1'b0;
        case (state)
            S_IDLE: begin
                if (done_in) state_nxt = (last_addr == '0) ? S_NEG : S_READ;
            end
            S_NEG:  state_nxt = S_FIN;
            S_READ: begin
                if (read_ok) begin
                    issue = 1'b1;
                    if (last_rd) state_nxt = S_FLUSH;
                end
            end
            S_FLUSH: begin
`ifdef BF_DRAIN_CHECKSUM_EN
                if (empty_after) begin
                    if (!csum_sent) csum_push = 1'b1;
                    else            state_nxt = S_FIN;
                end
`else
                if (empty_after) state_nxt = S_FIN;
`endif
            end
            S_FIN:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Stage p0: read issue -> data returning from SRAM
    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= S_IDLE;
            rd_ptr     <= '0;
            beats_left <= '0;
            neg_q      <= 1'b0;
            rd_vld_p0  <= 1'b0;
            rd_last_p0 <= 1'b0;
        end else begin
            state      <= state_nxt;
            rd_vld_p0  <= issue;
            rd_last_p0 <= issue && last_rd;
            if (state == S_IDLE && done_in) begin
                neg_q      <= 1'b0;
                rd_ptr     <= '0;
                beats_left <= {1'b0, last_addr} + (ADDR_W+1)'(1);
            end else if (issue) begin
                rd_ptr     <= rd_ptr + ADDR_W'(1);
                beats_left <= beats_left - (ADDR_W+1)'(1);
            end
            if (state == S_NEG) neg_q <= 1'b1;
        end
    end

    // Stage p1: buffered beats presented on the stream
    bf_skid_fifo #(.WIDTH(PW)) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .push       (push),
        .push_data  (push_data),
        .pop        (pop),
        .head_valid (head_valid),
        .head_data  (head_data),
        .occupancy  (occ)
    );

    assign sram_re    = issue;
    assign sram_addr  = rd_ptr;
    assign out_valid  = head_valid;
    assign out_data   = head_valid ? head_data[DATA_W-1:0] : '0;
    assign out_last   = head_valid && head_data[DATA_W];
    assign out_inf    = head_valid && !head_data[DATA_W+1]
                        && (head_data[DATA_W-1:0] == INF_VAL);
    assign neg_cycle  = neg_q;
    assign busy       = (state != S_IDLE) && (state != S_FIN);
    assign drain_done = (state == S_FIN);

endmodule

// File: tb/tb_bf_result_drain.sv
module tb_bf_result_drain;
    localparam int AW = 14;
    localparam int DW = 16;
`ifdef BF_DRAIN_CHECKSUM_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          done_in = 1'b0;
    logic [AW-1:0] last_addr = '0;
    logic          sram_re;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_rdata = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] out_data;
    logic          out_inf;
    logic          out_last;
    logic          neg_cycle;
    logic          busy;
    logic          drain_done;

    bf_result_drain dut (
        .clock      (clock),
        .reset      (reset),
        .done_in    (done_in),
        .last_addr  (last_addr),
        .sram_re    (sram_re),
        .sram_addr  (sram_addr),
        .sram_rdata (sram_rdata),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_inf    (out_inf),
        .out_last   (out_last),
        .neg_cycle  (neg_cycle),
        .busy       (busy),
        .drain_done (drain_done)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [DW-1:0] d;
        logic          inf;
        logic          last;
        int            cyc;
    } beat_t;

    int            checks = 0;
    int            failures = 0;
    int            cyc = 0;
    int            done_cyc, dd_cnt, dd_cyc, vld_cnt, neg_cyc, held, infl;
    beat_t         beats[$];
    logic          stall_prev = 1'b0;
    logic [DW+2:0] snap = '0;
    logic [DW-1:0] mem [0:15];
    logic          exp_inf [0:3] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic          pat [0:6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] rd_model(input logic [AW-1:0] a);
        if (a < AW'(16)) return mem[a[3:0]];
        return 16'hDEAD;
    endfunction

    always @(posedge clock) cyc <= cyc + 1;
    always @(posedge clock) if (sram_re) sram_rdata <= rd_model(sram_addr);

    always @(negedge clock) begin
        if (done_in && done_cyc < 0) done_cyc = cyc;
        if (sram_re)
            chk("rd_room", 32'((held + infl - int'(out_valid && out_ready)) < 2), 1);
        if (stall_prev) chk("stall_hold", 32'({out_valid, out_data, out_inf, out_last}), 32'(snap));
        stall_prev = out_valid && !out_ready;
        snap = {out_valid, out_data, out_inf, out_last};
        if (out_valid) vld_cnt++;
        if (out_valid && out_ready) beats.push_back('{out_data, out_inf, out_last, cyc});
        if (drain_done) begin
            dd_cnt++;
            dd_cyc = cyc;
        end
        if (neg_cycle && neg_cyc < 0) neg_cyc = cyc;
        held = held + infl - int'(out_valid && out_ready);
        infl = int'(sram_re);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_mon();
        beats.delete();
        done_cyc = -1;
        dd_cnt = 0;
        dd_cyc = -1;
        vld_cnt = 0;
        neg_cyc = -1;
        held = 0;
        infl = 0;
        stall_prev = 1'b0;
    endtask

    task automatic start(input logic [AW-1:0] a);
        done_in = 1'b1;
        last_addr = a;
        tick();
        done_in = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (dd_cnt == 0 && k < budget) begin
            tick();
            k++;
        end
        chk("drain_timeout", 32'(dd_cnt > 0), 1);
        tick();
        tick();
    endtask

    task automatic check_stream(input int n, input logic [DW-1:0] csum, input bit timing);
        chk("beat_count", beats.size(), n + EXTRA);
        for (int i = 0; i < n && i < beats.size(); i++) begin
            chk($sformatf("data%0d", i), beats[i].d, mem[i]);
            chk($sformatf("inf%0d", i), beats[i].inf, exp_inf[i]);
            chk($sformatf("last%0d", i), beats[i].last, 32'((i == n - 1) && (EXTRA == 0)));
        end
        if (EXTRA == 1 && beats.size() > n) begin
            chk("csum_data", beats[n].d, csum);
            chk("csum_inf", beats[n].inf, 0);
            chk("csum_last", beats[n].last, 1);
        end
        if (timing && beats.size() > 0) begin
            chk("first_lat", beats[0].cyc - done_cyc, 3);
            for (int i = 1; i < beats.size(); i++)
                chk($sformatf("back2back%0d", i), beats[i].cyc - beats[0].cyc, i);
        end
        chk("dd_count", dd_cnt, 1);
        if (beats.size() > 0)
            chk("dd_after_last", dd_cyc - beats[beats.size()-1].cyc, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        mem[0] = 16'h0000;
        mem[1] = 16'h0005;
        mem[2] = 16'hFFFF;
        mem[3] = 16'h000C;
        for (int i = 4; i < 16; i++) mem[i] = 16'h0100 + 16'(i);
        clear_mon();

        // reset state
        reset = 1'b0;
        repeat (3) tick();
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_re", sram_re, 0);
        chk("rst_addr", sram_addr, 0);
        chk("rst_data", out_data, 0);
        chk("rst_last", out_last, 0);
        chk("rst_neg", neg_cycle, 0);
        chk("rst_dd", drain_done, 0);
        reset = 1'b1;
        tick();

        // T1: four beats at full rate
        clear_mon();
        out_ready = 1'b1;
        start(3);
        chk("t1_busy", busy, 1);
        wait_done(60);
        check_stream(4, 16'h0010, 1'b1);
        chk("t1_neg", neg_cycle, 0);
        chk("t1_idle", busy, 0);

        // T2: negative cycle
        clear_mon();
        start(0);
        wait_done(20);
        chk("neg_lat", neg_cyc - done_cyc, 2);
        chk("neg_dd_lat", dd_cyc - done_cyc, 2);
        chk("neg_dd_count", dd_cnt, 1);
        chk("neg_no_valid", vld_cnt, 0);
        repeat (5) tick();
        chk("neg_hold", neg_cycle, 1);

        // T3: backpressure pattern
        clear_mon();
        out_ready = 1'b0;
        start(3);
        chk("neg_clear", neg_cycle, 0);
        for (int k = 0; k < 20 && !out_valid; k++) tick();
        chk("t3_valid_seen", out_valid, 1);
        for (int i = 0; i < 7; i++) begin
            out_ready = pat[i];
            tick();
        end
        out_ready = 1'b1;
        wait_done(60);
        check_stream(4, 16'h0010, 1'b0);

        // T4: reset mid-stream, then a short stream
        clear_mon();
        start(3);
        for (int k = 0; k < 20 && beats.size() < 2; k++) tick();
        reset = 1'b0;
        tick();
        chk("abort_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_re", sram_re, 0);
        chk("abort_data", out_data, 0);
        chk("abort_last", out_last, 0);
        chk("abort_dd", dd_cnt, 0);
        reset = 1'b1;
        tick();
        clear_mon();
        start(1);
        wait_done(40);
        check_stream(2, 16'h0005, 1'b1);

        // T5: done_in during READ is ignored
        clear_mon();
        start(3);
        tick();
        done_in = 1'b1;
        last_addr = 9;
        tick();
        done_in = 1'b0;
        wait_done(60);
        check_stream(4, 16'h0010, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
